// File: rtl/screen_draw_ctrl_pkg.sv
// rtl/screen_draw_ctrl_pkg.sv - shared screen constants, draw FSM states and image indices
package draw_pkg;

  localparam int X_SCREEN_PIXELS = 160;
  localparam int Y_SCREEN_PIXELS = 120;
  localparam int PIXEL_COUNT     = X_SCREEN_PIXELS * Y_SCREEN_PIXELS;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    FETCH = 2'd1,
    DRAIN = 2'd2,
    DONE  = 2'd3
  } state_t;

  localparam logic [1:0] START_SCREEN = 2'd0;
  localparam logic [1:0] GAME_SCREEN  = 2'd1;
  localparam logic [1:0] WIN_SCREEN   = 2'd2;
  localparam logic [1:0] LOSE_SCREEN  = 2'd3;

  // Requests for images the ROM bank does not hold fall back to the start screen.
  function automatic logic [1:0] clamp_sel(input logic [1:0] sel, input int num_images);
    return (int'(sel) >= num_images) ? START_SCREEN : sel;
  endfunction

endpackage

// File: rtl/screen_draw_ctrl_if.sv
// rtl/screen_draw_ctrl_if.sv - request, ROM and VGA-side signals of the draw controller
interface screen_draw_ctrl_if;

  logic        iStart;
  logic [1:0]  iImageSel;
  logic [2:0]  iRomData;
  logic [14:0] oRomAddr;
  logic [1:0]  oRomSel;
  logic [7:0]  oX;
  logic [6:0]  oY;
  logic [2:0]  oColour;
  logic        oPlot;
  logic        oBusy;
  logic        oDone;

  // Controller side.
  modport slave (
    input  iStart, iImageSel, iRomData,
    output oRomAddr, oRomSel, oX, oY, oColour, oPlot, oBusy, oDone
  );

  // Game FSM / ROM bank / VGA side.
  modport master (
    output iStart, iImageSel, iRomData,
    input  oRomAddr, oRomSel, oX, oY, oColour, oPlot, oBusy, oDone
  );

endinterface

// File: rtl/raster_counter.sv
// rtl/raster_counter.sv - x/y/linear-address raster walker with wrap and last-pixel flag
module raster_counter
  import draw_pkg::*;
#(
  parameter int X_PIX = X_SCREEN_PIXELS,
  parameter int Y_PIX = Y_SCREEN_PIXELS
) (
  input  logic        clk,
  input  logic        resetn,
  input  logic        en,
  output logic [7:0]  x,
  output logic [6:0]  y,
  output logic [14:0] addr,
  output logic        last
);

  localparam logic [7:0] X_MAX = 8'(X_PIX - 1);
  localparam logic [6:0] Y_MAX = 7'(Y_PIX - 1);

  assign last = (x == X_MAX) && (y == Y_MAX);

  // Step one pixel per enabled cycle; after the last pixel return to the origin
  // so the next draw starts at address 0 without an explicit clear.
  always_ff @(posedge clk) begin
    if (!resetn) begin
      x    <= '0;
      y    <= '0;
      addr <= '0;
    end else if (en) begin
      if (last) begin
        x    <= '0;
        y    <= '0;
        addr <= '0;
      end else if (x == X_MAX) begin
        x    <= '0;
        y    <= y + 7'd1;
        addr <= addr + 15'd1;
      end else begin
        x    <= x + 8'd1;
        addr <= addr + 15'd1;
      end
    end
  end

endmodule

// File: rtl/screen_draw_ctrl.sv
// rtl/screen_draw_ctrl.sv - full-screen ROM-to-VGA draw sequencer with one pending request
module screen_draw_ctrl
  import draw_pkg::*;
#(
  parameter int ROM_LATENCY = 1,
  parameter int NUM_IMAGES  = 4
) (
  input  logic               iClock,
  input  logic               iResetn,
  screen_draw_ctrl_if.slave  bus
);

  localparam logic [1:0] DRAIN_LAST = 2'(ROM_LATENCY - 1);

  state_t      state, state_next;
  logic        load;
  logic [1:0]  load_sel;
  logic [1:0]  active_sel;
  logic [1:0]  pending_sel;
  logic        pending_valid;
  logic [1:0]  drain_cnt;
  logic        busy;
  logic        cnt_en;
  logic [7:0]  cnt_x;
  logic [6:0]  cnt_y;
  logic [14:0] cnt_addr;
  logic        cnt_last;

  logic [ROM_LATENCY-1:0] valid_d;
  logic [7:0]             x_d [ROM_LATENCY];
  logic [6:0]             y_d [ROM_LATENCY];

  raster_counter u_raster (
    .clk    (iClock),
    .resetn (iResetn),
    .en     (cnt_en),
    .x      (cnt_x),
    .y      (cnt_y),
    .addr   (cnt_addr),
    .last   (cnt_last)
  );

  // Next state, draw launch and counter enable; a fresh request in DONE beats the pending one.
  always_comb begin
    state_next = state;
    load       = 1'b0;
    load_sel   = active_sel;
    cnt_en     = 1'b0;
    busy       = 1'b1;
    case (state)
      IDLE: begin
        busy = 1'b0;
        if (bus.iStart) begin
          load       = 1'b1;
          load_sel   = clamp_sel(bus.iImageSel, NUM_IMAGES);
          state_next = FETCH;
        end
      end
      FETCH: begin
        cnt_en = 1'b1;
        if (cnt_last) state_next = DRAIN;
      end
      DRAIN: begin
        if (drain_cnt == DRAIN_LAST) state_next = DONE;
      end
      DONE: begin
        if (bus.iStart) begin
          load       = 1'b1;
          load_sel   = clamp_sel(bus.iImageSel, NUM_IMAGES);
          state_next = FETCH;
        end else if (pending_valid) begin
          load       = 1'b1;
          load_sel   = pending_sel;
          state_next = FETCH;
        end else begin
          state_next = IDLE;
        end
      end
      default: state_next = IDLE;
    endcase
  end

  // State register.
  always_ff @(posedge iClock) begin
    if (!iResetn) state <= IDLE;
    else          state <= state_next;
  end

  // Active image stays fixed for the whole draw; requests during a draw park in the pending slot.
  always_ff @(posedge iClock) begin
    if (!iResetn) begin
      active_sel    <= '0;
      pending_sel   <= '0;
      pending_valid <= 1'b0;
    end else begin
      if (load) active_sel <= load_sel;
      if (state == DONE) begin
        pending_valid <= 1'b0;
      end else if (busy && bus.iStart) begin
        pending_valid <= 1'b1;
        pending_sel   <= clamp_sel(bus.iImageSel, NUM_IMAGES);
      end
    end
  end

  // Count the cycles spent waiting for the last ROM word.
  always_ff @(posedge iClock) begin
    if (!iResetn)            drain_cnt <= '0;
    else if (state == DRAIN) drain_cnt <= drain_cnt + 2'd1;
    else                     drain_cnt <= '0;
  end

  // Carry pixel coordinates alongside the ROM read so they meet the returned colour.
  always_ff @(posedge iClock) begin
    if (!iResetn) begin
      for (int i = 0; i < ROM_LATENCY; i++) begin
        valid_d[i] <= 1'b0;
        x_d[i]     <= '0;
        y_d[i]     <= '0;
      end
    end else begin
      valid_d[0] <= (state == FETCH);
      x_d[0]     <= cnt_x;
      y_d[0]     <= cnt_y;
      for (int i = 1; i < ROM_LATENCY; i++) begin
        valid_d[i] <= valid_d[i-1];
        x_d[i]     <= x_d[i-1];
        y_d[i]     <= y_d[i-1];
      end
    end
  end

  // Registered VGA write port; colour is forced to zero outside valid pixels.
  always_ff @(posedge iClock) begin
    if (!iResetn) begin
      bus.oPlot   <= 1'b0;
      bus.oX      <= '0;
      bus.oY      <= '0;
      bus.oColour <= '0;
    end else begin
      bus.oPlot   <= valid_d[ROM_LATENCY-1];
      bus.oX      <= x_d[ROM_LATENCY-1];
      bus.oY      <= y_d[ROM_LATENCY-1];
      bus.oColour <= valid_d[ROM_LATENCY-1] ? bus.iRomData : 3'd0;
    end
  end

  assign bus.oRomAddr = cnt_addr;
  assign bus.oRomSel  = active_sel;
  assign bus.oBusy    = busy;
  assign bus.oDone    = (state == DONE);

endmodule
